// File: rtl/program_sequencer_if.sv
// Bus bundle between the program sequencer, its instruction ROM and the processor core.
// The sequencer drives the master modport; the ROM and processor side use the slave modport.
interface program_sequencer_if #(
    parameter int ADDR_W = 5
);
    // ROM: mem_rd is high for exactly one cycle per fetch, and mem_data must be valid
    // on the following cycle. Processor: proc_run_n is low for exactly one cycle per
    // instruction, proc_din is stable from that cycle until proc_done, and proc_done
    // is a single-cycle completion strobe that is only honoured while executing.
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_data;
    logic [15:0]       proc_din;
    logic              proc_run_n;
    logic              proc_done;

    modport master (
        output mem_addr, mem_rd, proc_din, proc_run_n,
        input  mem_data, proc_done
    );

    modport slave (
        input  mem_addr, mem_rd, proc_din, proc_run_n,
        output mem_data, proc_done
    );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/issue controller: reads instructions from a 1-cycle ROM, issues them to the processor
// and advances the PC on completion. Define SINGLE_STEP_EN to add step-by-step execution.
module program_sequencer #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter logic [2:0]        HALT_OP  = 3'b111,
    parameter int                TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    program_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
`ifdef SINGLE_STEP_EN
    input  logic                 step,
    output logic                 step_wait,
`endif
    output logic [3:0]           state_dbg
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        WAIT_MEM  = 4'd2,
        DECODE    = 4'd3,
        ISSUE     = 4'd4,
        EXEC      = 4'd5,
        HALTED    = 4'd6,
        ERROR     = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        STEP_WAIT = 4'd8
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       din_q, din_d;
    logic              stop_pend_q, stop_pend_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [7:0]        wait_inc;
    logic              mem_rd_q;
    logic              run_n_q;
    logic              busy_st;
    logic              start_ok;
`ifdef SINGLE_STEP_EN
    logic              step_q;
    logic              step_rise;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= START_PC;
            instr_q     <= '0;
            din_q       <= '0;
            stop_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
            mem_rd_q    <= 1'b0;
            run_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            din_q       <= din_d;
            stop_pend_q <= stop_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            // Strobes are registered from the next state so they line up with FETCH/ISSUE.
            mem_rd_q    <= (state_d == FETCH);
            run_n_q     <= (state_d != ISSUE);
        end
    end

`ifdef SINGLE_STEP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step && !step_q;
`endif

    assign busy_st  = (state_q == FETCH) || (state_q == WAIT_MEM) || (state_q == DECODE) ||
                      (state_q == ISSUE) || (state_q == EXEC);
    // stop beats start whenever both arrive in a state that accepts start.
    assign start_ok = start && !stop;
    assign wait_inc = wait_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        din_d       = din_q;
        stop_pend_d = stop_pend_q;
        wait_cnt_d  = wait_cnt_q;

        if (busy_st && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE, HALTED, ERROR: begin
                if (start_ok) begin
                    pc_d        = START_PC;
                    stop_pend_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                instr_d = bus.mem_data;
                state_d = DECODE;
            end
            DECODE: begin
                if (instr_q[15:13] == HALT_OP) begin
                    state_d = HALTED;
                end else begin
                    din_d   = instr_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = EXEC;
            end
            EXEC: begin
                wait_cnt_d = wait_inc;
                // Completion takes priority over a timeout landing in the same cycle.
                if (bus.proc_done) begin
                    pc_d = pc_q + 1'b1;
                    if (stop_pend_q || stop) begin
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
`ifdef SINGLE_STEP_EN
                        state_d = STEP_WAIT;
`else
                        state_d = FETCH;
`endif
                    end
                end else if (wait_inc == 8'(TIMEOUT)) begin
                    state_d = ERROR;
                end
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (step_rise) begin
                    state_d = FETCH;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_addr   = pc_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.proc_din   = din_q;
    assign bus.proc_run_n = run_n_q;

    assign pc_out    = pc_q;
    assign busy      = busy_st;
    assign halted    = (state_q == HALTED);
    assign error     = (state_q == ERROR);
    assign state_dbg = state_q;
`ifdef SINGLE_STEP_EN
    assign step_wait = (state_q == STEP_WAIT);
`endif

endmodule
